// File: rtl/shift_right_seq_if.sv
// Start/done handshake and operand/result bus of the iterative right shifter.
interface shift_right_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] shift_amount;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;

    // Requester side (control unit / testbench).
    modport master (
        output start, op, data_in, shift_amount,
        input  data_out, busy, done
    );

    // Shifter side.
    modport slave (
        input  start, op, data_in, shift_amount,
        output data_out, busy, done
    );
endinterface

// File: rtl/shift_right_seq.sv
// Iterative right shifter: SHR / SHRA / ROR, one bit position per clock.
//
//  state | meaning
//  IDLE  | waiting for start; result held on data_out
//  SHIFT | shifting one bit per cycle until count reaches zero (busy)
//  DONE  | one-cycle done pulse; a new start is accepted here too
module shift_right_seq #(
    parameter int WIDTH      = 32,
    parameter int SHAMT_BITS = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_right_seq_if.slave bus
);
    localparam logic [1:0] OP_SHRA = 2'b01;
    localparam logic [1:0] OP_ROR  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      shreg_q, shreg_d;
    logic [SHAMT_BITS-1:0] count_q, count_d;
    logic [1:0]            op_q, op_d;
    logic [WIDTH-1:0]      data_out_q, data_out_d;
    logic                  accept;
    logic                  fill_bit;

    // Upper amount bits are deliberately ignored (amount wraps modulo WIDTH).
    wire unused_shamt_hi = ^bus.shift_amount[WIDTH-1:SHAMT_BITS];

    assign accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SHIFT;
            ST_SHIFT: if (count_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = accept ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from state only, so there is no input-to-output path.
    always_comb begin
        bus.busy     = (state_q == ST_SHIFT);
        bus.done     = (state_q == ST_DONE);
        bus.data_out = data_out_q;
    end

    // Fill bit entering at the MSB; reserved op falls through to logical.
    always_comb begin
        fill_bit = 1'b0;
        case (op_q)
            OP_SHRA: fill_bit = shreg_q[WIDTH-1];
            OP_ROR:  fill_bit = shreg_q[0];
            default: fill_bit = 1'b0;
        endcase
    end

    // Datapath next values: capture on accept, shift while counting, publish at zero.
    always_comb begin
        shreg_d    = shreg_q;
        count_d    = count_q;
        op_d       = op_q;
        data_out_d = data_out_q;
        if (accept) begin
            shreg_d = bus.data_in;
            count_d = bus.shift_amount[SHAMT_BITS-1:0];
            op_d    = bus.op;
        end else if (state_q == ST_SHIFT) begin
            if (count_q != '0) begin
                shreg_d = {fill_bit, shreg_q[WIDTH-1:1]};
                count_d = count_q - SHAMT_BITS'(1);
            end else begin
                data_out_d = shreg_q;
            end
        end
    end

    // Datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q    <= '0;
            count_q    <= '0;
            op_q       <= '0;
            data_out_q <= '0;
        end else begin
            shreg_q    <= shreg_d;
            count_q    <= count_d;
            op_q       <= op_d;
            data_out_q <= data_out_d;
        end
    end
endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq with hand-computed expected results.
module tb_shift_right_seq;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    shift_right_seq_if #(.WIDTH(WIDTH)) bus ();

    shift_right_seq #(.WIDTH(WIDTH), .SHAMT_BITS(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Present operands with start for one edge, then scramble the inputs.
    task automatic issue(input logic [31:0] d, input logic [31:0] amt, input logic [1:0] o);
        bus.start        = 1'b1;
        bus.data_in      = d;
        bus.shift_amount = amt;
        bus.op           = o;
        @(posedge clk);
        #1;
        bus.start        = 1'b0;
        bus.data_in      = $urandom;
        bus.shift_amount = $urandom;
        bus.op           = 2'($urandom_range(0, 3));
    endtask

    // Called #1 after the accepting edge; returns edges until done and busy samples seen.
    task automatic wait_done(output int edges, output int busy_cnt, output bit overlap);
        edges    = 0;
        busy_cnt = 0;
        overlap  = 1'b0;
        while (!bus.done && edges < 64) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk);
            #1;
            edges++;
        end
        if (bus.busy && bus.done) overlap = 1'b1;
        if (!bus.done) $display("FAIL timeout: done not seen within %0d cycles", edges);
    endtask

    task automatic run_op(input string tag, input logic [31:0] d, input logic [31:0] amt,
                          input logic [1:0] o, input logic [31:0] exp, input int n_eff);
        int edges, bc;
        bit ov;
        issue(d, amt, o);
        wait_done(edges, bc, ov);
        check({tag, " result"}, bus.data_out, exp);
        check({tag, " latency"}, 32'(edges), 32'(n_eff + 1));
        check({tag, " busy cycles"}, 32'(bc), 32'(n_eff + 1));
        check({tag, " busy&done"}, {31'd0, ov}, 32'd0);
    endtask

    initial begin
        int edges, bc, hold_val;
        bit ov;
        int saw_done;
        n_checks = 0;
        n_pass   = 0;

        // Reset held with start asserted.
        rst_n            = 1'b0;
        bus.start        = 1'b1;
        bus.op           = 2'b00;
        bus.data_in      = 32'hDEADBEEF;
        bus.shift_amount = 32'd2;
        repeat (3) @(posedge clk);
        #1;
        check("rst data_out", bus.data_out, 32'h0);
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst done", {31'd0, bus.done}, 32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post-rst done", {31'd0, bus.done}, 32'd0);
        check("post-rst busy", {31'd0, bus.busy}, 32'd0);

        // Main function across ops.
        run_op("shr 40>>3",   32'h00000028, 32'd3,  2'b00, 32'h00000005, 3);
        run_op("shra -40>>3", 32'hFFFFFFD8, 32'd3,  2'b01, 32'hFFFFFFFB, 3);
        run_op("shr -40>>3",  32'hFFFFFFD8, 32'd3,  2'b00, 32'h1FFFFFFB, 3);
        run_op("ror 1,1",     32'h00000001, 32'd1,  2'b10, 32'h80000000, 1);
        run_op("ror F,4",     32'h0000000F, 32'd4,  2'b10, 32'hF0000000, 4);
        run_op("rsvd op",     32'h80000000, 32'd4,  2'b11, 32'h08000000, 4);

        // Boundaries.
        run_op("amt 0",       32'h12345678, 32'd0,  2'b00, 32'h12345678, 0);
        run_op("amt 35",      32'h00000006, 32'd35, 2'b00, 32'h00000000, 3);
        run_op("amt 32",      32'hCAFEF00D, 32'd32, 2'b01, 32'hCAFEF00D, 0);
        run_op("shra 31",     32'h80000000, 32'd31, 2'b01, 32'hFFFFFFFF, 31);

        // Start while busy is ignored.
        issue(32'h00000028, 32'd3, 2'b00);
        bus.start        = 1'b1;
        bus.data_in      = 32'hFFFF0000;
        bus.shift_amount = 32'd0;
        bus.op           = 2'b10;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(edges, bc, ov);
        check("busy-start result", bus.data_out, 32'h00000005);
        check("busy-start latency", 32'(edges + 1), 32'd4);

        // Back-to-back: start presented in the DONE cycle.
        issue(32'h00000100, 32'd4, 2'b00);
        wait_done(edges, bc, ov);
        check("b2b first", bus.data_out, 32'h00000010);
        issue(32'h00000003, 32'd1, 2'b10);
        check("b2b no idle gap", {31'd0, bus.busy}, 32'd1);
        wait_done(edges, bc, ov);
        check("b2b second", bus.data_out, 32'h80000001);
        check("b2b latency", 32'(edges), 32'd2);

        // Result holds over idle cycles.
        hold_val = bus.data_out;
        repeat (10) @(posedge clk);
        #1;
        check("hold data_out", bus.data_out, 32'(hold_val));
        check("hold done low", {31'd0, bus.done}, 32'd0);

        // Reset two cycles into a 20-bit shift.
        issue(32'hABCD0000, 32'd20, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        check("mid busy before rst", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid rst data_out", bus.data_out, 32'h0);
        check("mid rst busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done++;
        end
        check("mid rst no done", 32'(saw_done), 32'd0);
        run_op("after rst", 32'hABCD0000, 32'd20, 2'b00, 32'h00000ABC, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
